mul_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one signed sequential multiplier among N requesters. It accepts one operand pair at a time through per-requester valid/ready handshakes and drives the multiplier's start/done protocol. After each result it clears the multiplier back to idle, then returns the product on a single tagged response channel. A watchdog ends any operation whose done never arrives, so one hung operation cannot block the shared multiplier.

---
 rtl/mul_share_arbiter.sv | 102 ++++++++++
 tb/tb_mul_share_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one signed sequential multiplier among N requesters
// Ports: req_valid/req_ready/req_a/req_b per-requester operand handshake (slice i = [i*W +: W]);
//        rsp_valid/rsp_ready/rsp_id/rsp_product/rsp_err tagged result channel;
//        mul_start/mul_multiplicand/mul_multiplier/mul_clr/mul_done/mul_product multiplier side.
module mul_share_arbiter #(
  parameter int N = 4,
  parameter int W = 32,
  parameter int TIMEOUT = 64,
  localparam int IDW = N > 1 ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [2*W-1:0]   rsp_product,
  output logic             rsp_err,
  output logic             mul_start,
  output logic [W-1:0]     mul_multiplicand,
  output logic [W-1:0]     mul_multiplier,
  output logic             mul_clr,
  input  logic             mul_done,
  input  logic [2*W-1:0]   mul_product
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, CLEAR = 3'd3, RESP = 3'd4;
  logic [2:0] state;
  logic [IDW-1:0] ptr, gid, idx;
  logic found;
  logic [TW-1:0] timer;
  logic [W-1:0] sel_a, sel_b;
  always_comb begin
    found = 1'b0;
    gid = '0;
    idx = '0;
    sel_a = '0;
    sel_b = '0;
    for (int j = 0; j < N; j++) begin
      idx = IDW'((int'(ptr) + j) % N);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gid = idx;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (gid == IDW'(j)) begin
        sel_a = req_a[j*W +: W];
        sel_b = req_b[j*W +: W];
      end
    end
  end
  assign req_ready = (state == IDLE && found) ? N'(1) << gid : '0;
  assign mul_start = state == ISSUE;
  assign mul_clr = state == CLEAR;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      rsp_id <= '0;
      rsp_product <= '0;
      rsp_err <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier <= '0;
      timer <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          mul_multiplicand <= sel_a;
          mul_multiplier <= sel_b;
          rsp_id <= gid;
          state <= ISSUE;
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: if (mul_done) begin
          rsp_product <= mul_product;
          rsp_err <= 1'b0;
          state <= CLEAR;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          rsp_product <= '0;
          rsp_err <= 1'b1;
          state <= CLEAR;
        end else begin
          timer <= timer + 1'b1;
        end
        CLEAR: state <= RESP;
        RESP: if (rsp_ready) begin
          ptr <= (rsp_id == IDW'(N - 1)) ? '0 : rsp_id + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: randomized scoreboard bench with a mock sequential multiplier
module tb_mul_share_arbiter;
  localparam int N = 4, W = 32, TIMEOUT = 64, IDW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_err, mul_start, mul_clr, mul_done;
  logic [IDW-1:0] rsp_id;
  logic [2*W-1:0] rsp_product, mul_product;
  logic [W-1:0] mul_multiplicand, mul_multiplier;
  logic signed [W-1:0] av[N], bv[N];
  int cur_k;
  logic hang, stale;
  typedef struct { int id; logic [2*W-1:0] prod; logic err; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int errs = 0, checks = 0, ptr_m = 0;
  logic m_active;
  int m_cnt;
  logic [2*W-1:0] m_prod;

  mul_share_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_clr(mul_clr), .mul_done(mul_done), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = av[i];
      req_b[i*W +: W] = bv[i];
    end
  end

  // mock multiplier: done rises cur_k cycles into WAIT and stays high until mul_clr
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_cnt <= 0;
      m_prod <= '0;
    end else if (mul_clr) begin
      m_active <= 1'b0;
    end else if (mul_start) begin
      m_active <= 1'b1;
      m_cnt <= cur_k;
      m_prod <= 64'(longint'($signed(mul_multiplicand)) * longint'($signed(mul_multiplier)));
    end else if (m_active && m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign mul_done = (m_active && m_cnt == 0 && !hang) || (stale && mul_start);
  assign mul_product = mul_done ? m_prod : '1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_id), 64'hFFFF);
      else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        chk("rsp_product", rsp_product, mon_e.prod);
        chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
      end
    end
  end

  task automatic rst_chk();
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_id", 64'(rsp_id), 0);
    chk("rst_rsp_product", rsp_product, 0);
    chk("rst_rsp_err", 64'(rsp_err), 0);
    chk("rst_mul_start", 64'(mul_start), 0);
    chk("rst_mul_clr", 64'(mul_clr), 0);
    chk("rst_operands", {mul_multiplicand, mul_multiplier}, 0);
  endtask

  task automatic do_op(input logic [N-1:0] mask, input int k, input logic hg, input logic st, input int hold,
                       input logic fixed, input logic signed [W-1:0] fa, input logic signed [W-1:0] fb);
    int eid, n, rsp_at, st_at, clr_at, st_cnt, clr_cnt, exp_rsp;
    logic rr_seen;
    exp_t e;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      av[i] = fixed ? fa : W'($urandom);
      bv[i] = fixed ? fb : W'($urandom);
    end
    cur_k = k;
    hang = hg;
    stale = st;
    req_valid = mask;
    eid = -1;
    for (int j = 0; j < N; j++) if (eid < 0 && mask[(ptr_m + j) % N]) eid = (ptr_m + j) % N;
    @(negedge clk);
    chk("grant", 64'(req_ready), 64'(1) << eid);
    if (req_ready == 0) return;
    e.id = eid;
    e.err = hg;
    e.prod = hg ? '0 : 64'(longint'(av[eid]) * longint'(bv[eid]));
    exp_q.push_back(e);
    exp_rsp = hg ? 3 + TIMEOUT : 4 + k;
    @(posedge clk); #1;
    req_valid = (hold > 0) ? mask : '0;
    n = 0; rsp_at = 0; st_at = 0; clr_at = 0; st_cnt = 0; clr_cnt = 0; rr_seen = 1'b0;
    while (rsp_at == 0 && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
      if (mul_start) begin
        st_cnt++;
        if (st_at == 0) st_at = n;
      end
      if (mul_clr) begin
        clr_cnt++;
        clr_at = n;
      end
      if (req_ready != 0) rr_seen = 1'b1;
      if (rsp_valid) rsp_at = n;
    end
    chk("start_cycle", 64'(st_at), 1);
    chk("start_count", 64'(st_cnt), 1);
    chk("clr_count", 64'(clr_cnt), 1);
    chk("clr_cycle", 64'(clr_at), 64'(exp_rsp - 1));
    chk("rsp_cycle", 64'(rsp_at), 64'(exp_rsp));
    chk("no_ready_busy", 64'(rr_seen), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 1);
      chk("hold_id", 64'(rsp_id), 64'(eid));
      chk("hold_product", rsp_product, e.prod);
      chk("hold_err", 64'(rsp_err), 64'(hg));
      chk("hold_no_ready", 64'(req_ready), 0);
      chk("hold_no_start", 64'(mul_start), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    ptr_m = (eid + 1) % N;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_valid = '0;
    rsp_ready = 1'b0;
    hang = 1'b0;
    stale = 1'b0;
    cur_k = 0;
    for (int i = 0; i < N; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end
    @(negedge clk);
    rst_chk();
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(4'b0100, 3, 1'b0, 1'b0, 0, 1'b1, -7, 6);
    do_op(4'b0011, 2, 1'b0, 1'b0, 10, 1'b0, 0, 0);
    @(posedge clk); #1;
    req_valid = '1;
    hang = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 rst_chk();
    @(posedge clk); #1;
    rst = 1'b0;
    hang = 1'b0;
    ptr_m = 0;
    repeat (8) do_op('1, int'($urandom_range(0, 5)), 1'b0, 1'b0, 0, 1'b0, 0, 0);
    do_op(4'b1000, 0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    do_op(4'b1000, 1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    do_op(4'b0010, 2, 1'b0, 1'b1, 0, 1'b0, 0, 0);
    do_op(4'b0001, TIMEOUT - 1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    do_op(4'b0100, 4, 1'b0, 1'b0, 0, 1'b1, 32'sh80000000, 32'sh80000000);
    repeat (20) do_op(N'($urandom_range(1, 15)), int'($urandom_range(0, 8)), 1'b0, 1'b0,
                      int'($urandom_range(0, 2)), 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
